// File: rtl/bp_pkg.sv
// bp_pkg: shared defaults and types for the branch-predictor update sequencer.
//   BP_IDX_W      default predictor table index width
//   BP_DEPTH      default number of in-flight branches tracked
//   bp_inflight_t queue entry {index, pred_taken}
//   bp_state_e    occupancy control state {EMPTY, TRACK, FULL}
package bp_pkg;

    localparam int unsigned BP_IDX_W = 8;
    localparam int unsigned BP_DEPTH = 4;

    typedef struct packed {
        logic [BP_IDX_W-1:0] index;
        logic                pred_taken;
    } bp_inflight_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        TRACK = 2'd1,
        FULL  = 2'd2
    } bp_state_e;

endpackage

// File: rtl/bp_inflight_fifo.sv
// bp_inflight_fifo: circular queue of in-flight branch entries.
//   clk, rst_n   clock, asynchronous active-low reset
//   push, pop    already-qualified enqueue/dequeue strobes (caller guarantees
//                push never overflows and pop never underflows)
//   flush        discard all entries; pointers return to zero
//   wr_data      entry to enqueue
//   rd_data      head entry (combinational read of the read pointer)
//   count        occupancy, 0..DEPTH
//   full, empty  occupancy flags
module bp_inflight_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 9
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           wr_data,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // DEPTH is a power of two, so pointer wrap is the natural rollover.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    assign rd_data = mem[rd_ptr];
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);

endmodule

// File: rtl/bp_update_sequencer.sv
// bp_update_sequencer: tracks branches from DECODE until EXEC resolves them and
// issues one aligned update pulse per resolve to the 2-bit counter table.
//   clk, rst_n        clock, asynchronous active-low reset
//   d_is_branch       push request; d_fsm_index / d_pred_taken form the entry
//   x_resolve_valid   resolve the oldest in-flight branch; x_taken = outcome
//   x_flush           squash everything in flight (same-cycle resolve still done)
//   fsm_set           one-cycle update strobe, one cycle after the resolve
//   fsm_set_index     table entry to update; fsm_feedback = outcome to apply
//   x_mispredict      registered; outcome differs from stored prediction
//   stall             queue full (registered state only)
//   inflight_count    occupancy
//   err_sticky        overflow or underflow seen since reset
//   resolved_cnt      saturating count of fsm_set pulses
//   mispredict_cnt    saturating count of x_mispredict pulses
// Optional feature macro: BP_UPDATE_STATS_EN enables the two statistics
// counters; without it both ports read 0 and no counter flops exist.
module bp_update_sequencer
    import bp_pkg::*;
#(
    parameter int unsigned DEPTH = BP_DEPTH,
    parameter int unsigned IDX_W = BP_IDX_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       d_is_branch,
    input  logic [IDX_W-1:0]           d_fsm_index,
    input  logic                       d_pred_taken,
    input  logic                       x_resolve_valid,
    input  logic                       x_taken,
    input  logic                       x_flush,
    output logic                       fsm_set,
    output logic [IDX_W-1:0]           fsm_set_index,
    output logic                       fsm_feedback,
    output logic                       x_mispredict,
    output logic                       stall,
    output logic [$clog2(DEPTH+1)-1:0] inflight_count,
    output logic                       err_sticky,
    output logic [15:0]                resolved_cnt,
    output logic [15:0]                mispredict_cnt
);

    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    bp_state_e      state;
    bp_state_e      state_next;
    logic           full;
    logic           empty;
    logic           push_ok;
    logic           pop_ok;
    logic           overflow;
    logic           underflow;
    logic [IDX_W:0] head;

    // A pop frees a slot in the same cycle, so a push into a full queue is
    // accepted when paired with a pop. A push during flush is dropped silently.
    assign pop_ok    = x_resolve_valid && !empty;
    assign push_ok   = d_is_branch && !x_flush && (!full || pop_ok);
    assign overflow  = d_is_branch && !x_flush && full && !pop_ok;
    assign underflow = x_resolve_valid && empty;

    bp_inflight_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (IDX_W + 1)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push_ok),
        .pop     (pop_ok),
        .flush   (x_flush),
        .wr_data ({d_fsm_index, d_pred_taken}),
        .rd_data (head),
        .count   (inflight_count),
        .full    (full),
        .empty   (empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (x_flush) begin
            state_next = EMPTY;
        end else if (push_ok && !pop_ok) begin
            state_next = (inflight_count == CNT_W'(DEPTH - 1)) ? FULL : TRACK;
        end else if (pop_ok && !push_ok) begin
            state_next = (inflight_count == CNT_W'(1)) ? EMPTY : TRACK;
        end
    end

    assign stall = (state == FULL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_set       <= 1'b0;
            fsm_set_index <= '0;
            fsm_feedback  <= 1'b0;
            x_mispredict  <= 1'b0;
            err_sticky    <= 1'b0;
        end else begin
            fsm_set      <= pop_ok;
            x_mispredict <= pop_ok && (x_taken != head[0]);
            if (pop_ok) begin
                fsm_set_index <= head[IDX_W:1];
                fsm_feedback  <= x_taken;
            end
            if (overflow || underflow) begin
                err_sticky <= 1'b1;
            end
        end
    end

`ifdef BP_UPDATE_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resolved_cnt   <= '0;
            mispredict_cnt <= '0;
        end else begin
            if (fsm_set && (resolved_cnt != '1)) begin
                resolved_cnt <= resolved_cnt + 16'd1;
            end
            if (x_mispredict && (mispredict_cnt != '1)) begin
                mispredict_cnt <= mispredict_cnt + 16'd1;
            end
        end
    end
`else
    assign resolved_cnt   = '0;
    assign mispredict_cnt = '0;
`endif

endmodule

// File: tb/tb_bp_update_sequencer.sv
// tb_bp_update_sequencer: directed scenarios plus randomized traffic checked
// against a queue-based reference model of the in-flight branch list.
module tb_bp_update_sequencer;
    import bp_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned IDX_W = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             d_is_branch = 1'b0;
    logic [IDX_W-1:0] d_fsm_index = '0;
    logic             d_pred_taken = 1'b0;
    logic             x_resolve_valid = 1'b0;
    logic             x_taken = 1'b0;
    logic             x_flush = 1'b0;
    logic             fsm_set;
    logic [IDX_W-1:0] fsm_set_index;
    logic             fsm_feedback;
    logic             x_mispredict;
    logic             stall;
    logic [2:0]       inflight_count;
    logic             err_sticky;
    logic [15:0]      resolved_cnt;
    logic [15:0]      mispredict_cnt;

    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    // reference model state
    bp_inflight_t     mq[$];
    logic             m_set, m_fb, m_mis, m_err;
    logic [IDX_W-1:0] m_idx;
    int unsigned      m_res_cnt, m_mis_cnt;

    bp_update_sequencer #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .d_is_branch     (d_is_branch),
        .d_fsm_index     (d_fsm_index),
        .d_pred_taken    (d_pred_taken),
        .x_resolve_valid (x_resolve_valid),
        .x_taken         (x_taken),
        .x_flush         (x_flush),
        .fsm_set         (fsm_set),
        .fsm_set_index   (fsm_set_index),
        .fsm_feedback    (fsm_feedback),
        .x_mispredict    (x_mispredict),
        .stall           (stall),
        .inflight_count  (inflight_count),
        .err_sticky      (err_sticky),
        .resolved_cnt    (resolved_cnt),
        .mispredict_cnt  (mispredict_cnt)
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        mq.delete();
        m_set = 0; m_fb = 0; m_mis = 0; m_err = 0; m_idx = '0;
        m_res_cnt = 0; m_mis_cnt = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        d_is_branch = 0; x_resolve_valid = 0; x_flush = 0;
        model_clear();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Drive one cycle of inputs, clock it, then advance the model.
    task automatic cycle(input logic push, input logic [IDX_W-1:0] idx, input logic pred,
                         input logic res, input logic tk, input logic fl);
        int sz;
        bp_inflight_t h;
        d_is_branch = push; d_fsm_index = idx; d_pred_taken = pred;
        x_resolve_valid = res; x_taken = tk; x_flush = fl;
        @(posedge clk);
        #1;
        if (m_set) m_res_cnt++;
        if (m_mis) m_mis_cnt++;
        sz = mq.size();
        m_set = res && (sz > 0);
        m_mis = 0;
        if (res && sz == 0) m_err = 1;
        if (m_set) begin
            h = mq.pop_front();
            m_idx = h.index;
            m_fb = tk;
            m_mis = (tk != h.pred_taken);
        end
        if (push && !fl) begin
            if (sz < DEPTH || m_set) mq.push_back('{index: idx, pred_taken: pred});
            else m_err = 1;
        end
        if (fl) mq.delete();
        d_is_branch = 0; x_resolve_valid = 0; x_flush = 0;
    endtask

    task automatic test_reset();
        do_reset();
        n_total++; if (fsm_set !== 1'b0) $display("FAIL reset_fsm_set got=%b exp=0", fsm_set); else n_pass++;
        n_total++; if (fsm_set_index !== '0) $display("FAIL reset_index got=%0d exp=0", fsm_set_index); else n_pass++;
        n_total++; if ({fsm_feedback, x_mispredict, stall, err_sticky} !== 4'b0)
            $display("FAIL reset_flags got=%b exp=0000", {fsm_feedback, x_mispredict, stall, err_sticky}); else n_pass++;
        n_total++; if (inflight_count !== 3'd0) $display("FAIL reset_count got=%0d exp=0", inflight_count); else n_pass++;
        n_total++; if ({resolved_cnt, mispredict_cnt} !== 32'd0)
            $display("FAIL reset_stats got=%0d/%0d exp=0/0", resolved_cnt, mispredict_cnt); else n_pass++;
    endtask

    task automatic test_single();
        do_reset();
        cycle(1, 8'd3, 1, 0, 0, 0);
        cycle(0, 8'd0, 0, 1, 0, 0);
        n_total++; if (fsm_set !== 1'b1) $display("FAIL single_set got=%b exp=1", fsm_set); else n_pass++;
        n_total++; if (fsm_set_index !== 8'd3) $display("FAIL single_index got=%0d exp=3", fsm_set_index); else n_pass++;
        n_total++; if (fsm_feedback !== 1'b0) $display("FAIL single_feedback got=%b exp=0", fsm_feedback); else n_pass++;
        n_total++; if (x_mispredict !== 1'b1) $display("FAIL single_mispredict got=%b exp=1", x_mispredict); else n_pass++;
        cycle(0, 8'd0, 0, 0, 0, 0);
        n_total++; if (fsm_set !== 1'b0) $display("FAIL single_pulse_width got=%b exp=0", fsm_set); else n_pass++;
    endtask

    task automatic test_fill_drain();
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1, 8'(i), 0, 0, 0, 0);
        n_total++; if (stall !== 1'b1) $display("FAIL fill_stall got=%b exp=1", stall); else n_pass++;
        n_total++; if (inflight_count !== 3'd4) $display("FAIL fill_count got=%0d exp=4", inflight_count); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            cycle(0, 8'd0, 0, 1, 1, 0);
            n_total++; if (fsm_set !== 1'b1 || fsm_set_index !== 8'(i))
                $display("FAIL drain_order set=%b idx=%0d exp set=1 idx=%0d", fsm_set, fsm_set_index, i); else n_pass++;
            if (i == 0) begin
                n_total++; if (stall !== 1'b0) $display("FAIL drain_stall_fall got=%b exp=0", stall); else n_pass++;
            end
        end
        n_total++; if (inflight_count !== 3'd0) $display("FAIL drain_count got=%0d exp=0", inflight_count); else n_pass++;
    endtask

    task automatic test_full_push_pop();
        logic [IDX_W-1:0] exp_seq [4] = '{8'd11, 8'd12, 8'd13, 8'd5};
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1, 8'(10 + i), 1, 0, 0, 0);
        cycle(1, 8'd5, 0, 1, 1, 0);
        n_total++; if (inflight_count !== 3'd4) $display("FAIL fullpp_count got=%0d exp=4", inflight_count); else n_pass++;
        n_total++; if (err_sticky !== 1'b0) $display("FAIL fullpp_err got=%b exp=0", err_sticky); else n_pass++;
        n_total++; if (fsm_set_index !== 8'd10) $display("FAIL fullpp_head got=%0d exp=10", fsm_set_index); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            cycle(0, 8'd0, 0, 1, 0, 0);
            n_total++; if (fsm_set_index !== exp_seq[i])
                $display("FAIL fullpp_order got=%0d exp=%0d", fsm_set_index, exp_seq[i]); else n_pass++;
        end
    endtask

    task automatic test_overflow_underflow();
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1, 8'(40 + i), 0, 0, 0, 0);
        cycle(1, 8'd99, 0, 0, 0, 0);
        n_total++; if (err_sticky !== 1'b1) $display("FAIL overflow_err got=%b exp=1", err_sticky); else n_pass++;
        n_total++; if (inflight_count !== 3'd4) $display("FAIL overflow_count got=%0d exp=4", inflight_count); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            cycle(0, 8'd0, 0, 1, 0, 0);
            n_total++; if (fsm_set_index !== 8'(40 + i))
                $display("FAIL overflow_drop got=%0d exp=%0d", fsm_set_index, 40 + i); else n_pass++;
        end
        cycle(0, 8'd0, 0, 1, 0, 0);
        n_total++; if (fsm_set !== 1'b0) $display("FAIL overflow_absent got=%b exp=0", fsm_set); else n_pass++;
        do_reset();
        cycle(0, 8'd0, 0, 1, 1, 0);
        n_total++; if (fsm_set !== 1'b0) $display("FAIL underflow_set got=%b exp=0", fsm_set); else n_pass++;
        n_total++; if (err_sticky !== 1'b1) $display("FAIL underflow_err got=%b exp=1", err_sticky); else n_pass++;
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1, 8'(20 + i), 1, 0, 0, 0);
        cycle(1, 8'd23, 1, 1, 1, 1);
        n_total++; if (fsm_set !== 1'b1 || fsm_set_index !== 8'd20)
            $display("FAIL flush_resolve set=%b idx=%0d exp set=1 idx=20", fsm_set, fsm_set_index); else n_pass++;
        n_total++; if (inflight_count !== 3'd0) $display("FAIL flush_count got=%0d exp=0", inflight_count); else n_pass++;
        n_total++; if (err_sticky !== 1'b0) $display("FAIL flush_err got=%b exp=0", err_sticky); else n_pass++;
        cycle(0, 8'd0, 0, 1, 0, 0);
        n_total++; if (fsm_set !== 1'b0) $display("FAIL flush_push_absent got=%b exp=0", fsm_set); else n_pass++;
    endtask

    task automatic test_async_reset();
        do_reset();
        cycle(1, 8'd7, 0, 0, 0, 0);
        cycle(1, 8'd8, 0, 1, 0, 0);
        rst_n = 1'b0;
        #1;
        n_total++; if (fsm_set !== 1'b0) $display("FAIL async_reset_set got=%b exp=0", fsm_set); else n_pass++;
        n_total++; if (inflight_count !== 3'd0) $display("FAIL async_reset_count got=%0d exp=0", inflight_count); else n_pass++;
        do_reset();
    endtask

    task automatic test_stats();
        logic [15:0] exp_r, exp_m;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            cycle(1, 8'(i), 1, 0, 0, 0);
            cycle(0, 8'd0, 0, 1, (i < 4) ? 1'b0 : 1'b1, 0);
        end
        cycle(0, 8'd0, 0, 0, 0, 0);
`ifdef BP_UPDATE_STATS_EN
        exp_r = 16'd10; exp_m = 16'd4;
`else
        exp_r = 16'd0; exp_m = 16'd0;
`endif
        n_total++; if (resolved_cnt !== exp_r) $display("FAIL stats_resolved got=%0d exp=%0d", resolved_cnt, exp_r); else n_pass++;
        n_total++; if (mispredict_cnt !== exp_m) $display("FAIL stats_mispredict got=%0d exp=%0d", mispredict_cnt, exp_m); else n_pass++;
    endtask

    task automatic test_random();
        logic p, r, f;
        do_reset();
        for (int c = 0; c < 500; c++) begin
            p = ($urandom_range(0, 99) < 55);
            r = ($urandom_range(0, 99) < 50);
            f = ($urandom_range(0, 99) < 4);
            cycle(p, 8'($urandom), 1'($urandom), r, 1'($urandom), f);
            n_total++; if (fsm_set !== m_set) $display("FAIL rand_set cyc=%0d got=%b exp=%b", c, fsm_set, m_set); else n_pass++;
            n_total++; if (fsm_set_index !== m_idx || fsm_feedback !== m_fb)
                $display("FAIL rand_update cyc=%0d got=%0d/%b exp=%0d/%b", c, fsm_set_index, fsm_feedback, m_idx, m_fb); else n_pass++;
            n_total++; if (x_mispredict !== m_mis) $display("FAIL rand_mispredict cyc=%0d got=%b exp=%b", c, x_mispredict, m_mis); else n_pass++;
            n_total++; if (inflight_count !== 3'(mq.size()) || stall !== (mq.size() == DEPTH))
                $display("FAIL rand_occupancy cyc=%0d got=%0d/%b exp=%0d", c, inflight_count, stall, mq.size()); else n_pass++;
            n_total++; if (err_sticky !== m_err) $display("FAIL rand_err cyc=%0d got=%b exp=%b", c, err_sticky, m_err); else n_pass++;
`ifdef BP_UPDATE_STATS_EN
            n_total++; if (resolved_cnt !== 16'(m_res_cnt) || mispredict_cnt !== 16'(m_mis_cnt))
                $display("FAIL rand_stats cyc=%0d got=%0d/%0d exp=%0d/%0d", c, resolved_cnt, mispredict_cnt, m_res_cnt, m_mis_cnt); else n_pass++;
`endif
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_single();
        test_fill_drain();
        test_full_push_pop();
        test_overflow_underflow();
        test_flush();
        test_async_reset();
        test_stats();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/bp_update_sequencer.md
# bp_update_sequencer

Sequences outcome updates into the branch predictor's 2-bit counter table. Every branch accepted at DECODE is tracked in order until EXEC resolves it. On resolution the block issues one `fsm_set`/`fsm_set_index`/`fsm_feedback` pulse aligned to the correct table entry, which replaces ad-hoc delay-line buffering. It sits between the decode/exec pipeline control and the predictor's state-machine update port, and it also flags mispredictions and back-pressures decode when its tracking queue is full.

## Interface
- `DEPTH`, 4: maximum in-flight branches; power of two, 2..16
- `IDX_W`, 8: width of a predictor table index
- `clk` in 1: sole clock, rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `d_is_branch` in 1: DECODE has a branch; push request
- `d_fsm_index` in IDX_W: table entry assigned to that branch
- `d_pred_taken` in 1: prediction FETCH used for that branch (`f_predict_valid` at fetch time)
- `x_resolve_valid` in 1: EXEC resolves the oldest in-flight branch
- `x_taken` in 1: actual outcome; qualified by `x_resolve_valid`
- `x_flush` in 1: squash all in-flight branches
- `fsm_set` out 1: one-cycle update strobe to the counter table
- `fsm_set_index` out IDX_W: entry to update
- `fsm_feedback` out 1: taken/not-taken to apply
- `x_mispredict` out 1: registered; the resolved outcome differs from the stored prediction
- `stall` out 1: queue full; decode must hold
- `inflight_count` out clog2(DEPTH+1): occupancy
- `err_sticky` out 1: overflow or underflow seen; cleared only by reset
- `resolved_cnt` out 16: stats, see Configuration
- `mispredict_cnt` out 16: stats, see Configuration

## Operation
- Circular queue of DEPTH entries {index, pred_taken}, with write pointer, read pointer and count.
- **Push:** `d_is_branch` and count < DEPTH stores the entry at the write pointer. Pointers wrap modulo DEPTH.
- **Pop:** `x_resolve_valid` and count > 0 reads the head. The next cycle drives `fsm_set`=1, `fsm_set_index`=head.index, `fsm_feedback`=`x_taken`, and `x_mispredict`=(`x_taken` != head.pred_taken).
- **Push and pop in the same cycle:** both occur and count is unchanged. A push while count==DEPTH is accepted only if a pop happens in the same cycle.
- **Overflow:** a push while full with no pop is dropped and sets `err_sticky`.
- **Underflow:** a resolve while empty is ignored, produces no `fsm_set`, and sets `err_sticky`.
- **Flush:** a resolve in the same cycle is still performed first. Then all entries are discarded (count=0, pointers equal), and a push in the flush cycle is dropped silently (no error).
- **Control states:** EMPTY (count=0), TRACK (0<count<DEPTH), FULL (count=DEPTH). Transitions:
  - push only: +1
  - pop only: −1
  - both: hold
  - flush: → EMPTY
- `stall` = (state==FULL), derived from registered state only, with no combinational input path.

## Timing
- Reset values: all outputs 0; pointers, count and state = EMPTY; queue contents don't-care.
- Resolve-to-update latency is 1 cycle. `fsm_set` is high for exactly one cycle per valid resolve, so back-to-back resolves give back-to-back pulses.
- A branch pushed in cycle N can be resolved from cycle N+1 onward.
- `stall` rises the cycle after the filling push and falls the cycle after the freeing pop.
- If reset asserts mid-operation, pending `fsm_set` is cancelled immediately (asynchronously) and the queue empties.

## Configuration
- `BP_UPDATE_STATS_EN`:
  - Defined: `resolved_cnt` increments on each `fsm_set` and `mispredict_cnt` on each `x_mispredict`. Both are 16-bit, saturate at 0xFFFF and reset to 0.
  - Undefined: both ports are present but tied to 0, and no counter flops exist.

## Structure
- Package `bp_pkg`: `BP_IDX_W`, `BP_DEPTH` defaults, the entry struct `bp_inflight_t` {index, pred_taken}, and the state enum {EMPTY, TRACK, FULL}.
- Sub-module `bp_inflight_fifo` holds storage, pointers and count, with flush input and full/empty outputs. The top level adds the state, output registers, error and stats logic.

## Test plan
- **Single branch:** push idx=3/pred=1; resolve next cycle with taken=0 → one cycle later `fsm_set`=1, index=3, feedback=0, `x_mispredict`=1.
- **Fill and drain:** 4 pushes (idx 0..3) → `stall`=1 and `inflight_count`=4; 4 resolves → `fsm_set_index` sequence 0,1,2,3 in order, then `stall`=0.
- **Full with simultaneous push and pop:** push idx=5 while resolving → count stays 4, `err_sticky`=0, and idx 5 emerges last.
- **Overflow and underflow:** push while full with no pop → `err_sticky`=1 and the entry is not stored. Resolve while empty after reset → no `fsm_set`, `err_sticky`=1.
- **Flush:** 3 in flight, then resolve+flush+push in one cycle → one `fsm_set` for the oldest entry, then count=0 and the pushed branch is absent.
- **Stats:** with `BP_UPDATE_STATS_EN`, 10 resolves with 4 mispredicts → `resolved_cnt`=10, `mispredict_cnt`=4. Without it, both read 0.
